// File: rtl/scroll_ctrl.sv
// Scrolling-display sequencer: RUN/PAUSE/CLEAR/IDLE control, scroll step timing,
// message offset and digit-scan multiplexing for the character datapath.
module scroll_ctrl #(
    parameter int SCROLL_DIV = 50_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter int MSG_LEN    = 16,
    parameter int NUM_DIG    = 8,
    localparam int OW  = $clog2(MSG_LEN),
    localparam int SW  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1,
    localparam int CW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1,
    localparam int NW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clr_in,
    input  logic               pause_in,
    output logic [1:0]         state,
    output logic [OW-1:0]      offset,
    output logic [SW-1:0]      scan_sel,
    output logic [OW-1:0]      char_idx,
    output logic [NUM_DIG-1:0] an,
    output logic               step_pulse
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_CLEAR = 2'b11;

    localparam logic [CW-1:0] SCROLL_LAST = CW'(SCROLL_DIV - 1);
    localparam logic [NW-1:0] SCAN_LAST   = NW'(SCAN_DIV - 1);
    localparam logic [OW-1:0] OFF_LAST    = OW'(MSG_LEN - 1);
    localparam logic [SW-1:0] SEL_LAST    = SW'(NUM_DIG - 1);
    localparam int            SUMW        = ((OW > SW) ? OW : SW) + 1;

    logic [1:0]    r_clr_sync;
    logic [1:0]    r_pause_sync;
    logic          r_clr_d;
    logic [CW-1:0] r_scroll_cnt;
    logic [NW-1:0] r_scan_cnt;

    logic          w_clr_edge;
    logic          w_pause_s;
    logic          w_term;
    logic          w_step;
    logic          w_scan_wrap;
    logic [1:0]    w_next;
    logic [SW-1:0] w_scan_next;
    logic [SUMW-1:0] w_sum;

    assign w_clr_edge  = r_clr_sync[1] & ~r_clr_d;
    assign w_pause_s   = r_pause_sync[1];
    assign w_term      = (state == S_RUN) && (r_scroll_cnt == SCROLL_LAST);
    // A clear edge landing on the terminal count suppresses the step entirely.
    assign w_step      = w_term & ~w_clr_edge;
    assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);

    always_comb begin
        w_next = state;
        if (w_clr_edge)
            w_next = S_CLEAR;
        else if (!enable)
            w_next = S_IDLE;
        else
            w_next = w_pause_s ? S_PAUSE : S_RUN;
    end

    always_comb begin
        w_scan_next = scan_sel;
        if (w_scan_wrap)
            w_scan_next = (scan_sel == SEL_LAST) ? '0 : scan_sel + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_sync   <= '0;
            r_pause_sync <= '0;
            r_clr_d      <= 1'b0;
        end else begin
            r_clr_sync   <= {r_clr_sync[0], clr_in};
            r_pause_sync <= {r_pause_sync[0], pause_in};
            r_clr_d      <= r_clr_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            r_scroll_cnt <= '0;
            offset       <= '0;
            step_pulse   <= 1'b0;
        end else begin
            state      <= w_next;
            step_pulse <= w_step;
            if (w_clr_edge || state == S_IDLE || state == S_CLEAR)
                r_scroll_cnt <= '0;
            else if (state == S_RUN)
                r_scroll_cnt <= w_term ? '0 : r_scroll_cnt + CW'(1);
            if (w_clr_edge)
                offset <= '0;
            else if (w_step)
                offset <= (offset == OFF_LAST) ? '0 : offset + OW'(1);
        end
    end

    // Scanning never stops so PAUSE/CLEAR keep the digits lit; IDLE only blanks the anodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            scan_sel   <= '0;
            an         <= '1;
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + NW'(1);
            scan_sel   <= w_scan_next;
            an         <= (w_next == S_IDLE) ? '1 : ~(NUM_DIG'(1) << w_scan_next);
        end
    end

    assign w_sum    = SUMW'(offset) + SUMW'(scan_sel);
    assign char_idx = (w_sum >= SUMW'(MSG_LEN)) ? OW'(w_sum - SUMW'(MSG_LEN)) : OW'(w_sum);
endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl; step_pulse events are checked against a queue of expected offsets.
module tb_scroll_ctrl;
    localparam int SD = 4, SCD = 2, ML = 5, ND = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clr_in = 1'b0;
    logic       pause_in = 1'b0;
    logic [1:0] state;
    logic [2:0] offset;
    logic [1:0] scan_sel;
    logic [2:0] char_idx;
    logic [3:0] an;
    logic       step_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];
    bit hit31 = 0;
    bit hit40 = 0;

    scroll_ctrl #(.SCROLL_DIV(SD), .SCAN_DIV(SCD), .MSG_LEN(ML), .NUM_DIG(ND)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr_in(clr_in), .pause_in(pause_in),
        .state(state), .offset(offset), .scan_sel(scan_sel), .char_idx(char_idx),
        .an(an), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_pulse && n < 20);
        chk("step_seen", step_pulse, 1);
    endtask

    // Scoreboard side: every step pulse must match the next queued offset.
    always @(negedge clk) begin
        if (rst_n) begin
            int exp_ci;
            exp_ci = (int'(offset) + int'(scan_sel)) % ML;
            chk("char_idx", char_idx, exp_ci);
            if (offset == 3'd3 && scan_sel == 2'd3) begin
                hit31 = 1;
                chk("char_idx_o3_s3", char_idx, 1);
            end
            if (offset == 3'd4 && scan_sel == 2'd0) begin
                hit40 = 1;
                chk("char_idx_o4_s0", char_idx, 4);
            end
            if (step_pulse) begin
                chk("step_expected", sb.size() > 0, 1);
                if (sb.size() > 0) chk("step_offset", offset, sb.pop_front());
            end
        end
    end

    initial begin
        int n;
        int mask;
        logic [3:0] exp_an;
        #2;
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_offset", offset, 0);
        chk("rst_an", an, 4'hF);
        chk("rst_step", step_pulse, 0);
        chk("rst_scan", scan_sel, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_state", state, 0);
        chk("idle_an", an, 4'hF);

        // RUN: steps every 4 clocks with wrap 4 -> 0
        enable = 1'b1;
        sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(4); sb.push_back(0);
        wait_step(n); chk("first_step_lat", n, 5);
        for (int i = 0; i < 4; i++) begin
            wait_step(n); chk("step_period", n, 4);
        end
        chk("wrap_offset", offset, 0);

        // PAUSE set with scroll count at 3: one more step, then frozen at count 2
        repeat (3) tick();
        sb.push_back(1);
        pause_in = 1'b1;
        tick(); chk("step_before_pause", step_pulse, 1); chk("run_lat1", state, 1);
        tick(); chk("run_lat2", state, 1);
        tick(); chk("pause_latency", state, 2);
        mask = 0;
        repeat (17) begin
            tick();
            chk("pause_state", state, 2);
            chk("pause_offset", offset, 1);
            exp_an = ~(4'b0001 << scan_sel);
            chk("pause_an", an, exp_an);
            mask = mask | (1 << scan_sel);
        end
        chk("pause_scan_all", mask, 15);
        pause_in = 1'b0;
        repeat (3) tick();
        chk("resume_state", state, 1);
        sb.push_back(2);
        wait_step(n); chk("resume_remaining", n, 2);

        // IDLE holds offset and blanks anodes
        sb.push_back(3);
        wait_step(n); chk("step_period", n, 4);
        enable = 1'b0;
        tick(); chk("idle_entry", state, 0); chk("idle_blank", an, 4'hF);
        repeat (10) begin
            tick(); chk("idle_hold3", offset, 3); chk("idle_blank", an, 4'hF);
        end
        enable = 1'b1;
        sb.push_back(4);
        wait_step(n); chk("idle_resume_lat", n, 5);
        enable = 1'b0;
        repeat (11) begin
            tick(); chk("idle_hold4", offset, 4);
        end
        enable = 1'b1;
        sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
        wait_step(n); chk("idle_resume_lat", n, 5);
        for (int i = 0; i < 3; i++) begin
            wait_step(n); chk("step_period", n, 4);
        end

        // Held clear at offset 3: exactly one CLEAR cycle, then normal scrolling
        for (int i = 0; i < 11; i++) sb.push_back((i + 1) % ML);
        clr_in = 1'b1;
        tick(); chk("clr_lat1", state, 1);
        tick(); chk("clr_lat2", state, 1);
        tick(); chk("clr_state", state, 3); chk("clr_offset", offset, 0); chk("clr_step", step_pulse, 0);
        tick(); chk("clr_to_run", state, 1);
        repeat (46) begin
            tick(); chk("no_reclear", state, 1);
        end
        clr_in = 1'b0;
        chk("sb_drained_clr", sb.size(), 0);

        // Clear edge on the terminal-count cycle
        sb.push_back(2); sb.push_back(3);
        wait_step(n); chk("post_clr_step", n, 2);
        wait_step(n); chk("step_period", n, 4);
        tick();
        clr_in = 1'b1;
        repeat (3) tick();
        chk("clr_term_state", state, 3);
        chk("clr_term_offset", offset, 0);
        chk("clr_term_step", step_pulse, 0);
        clr_in = 1'b0;
        tick(); chk("clr_term_run", state, 1);

        // Async reset mid-RUN at offset 3
        sb.push_back(1); sb.push_back(2); sb.push_back(3);
        for (int i = 0; i < 3; i++) wait_step(n);
        tick();
        chk("pre_reset_offset", offset, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_offset", offset, 0);
        chk("arst_an", an, 4'hF);
        chk("arst_step", step_pulse, 0);
        chk("arst_scan", scan_sel, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("sb_drained_end", sb.size(), 0);
        chk("hit_o3_s3", hit31, 1);
        chk("hit_o4_s0", hit40, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
